// File: rtl/carregador_instrucoes_pkg.sv
// Shared definitions for the program loader and the instruction-memory reader.
// Memory geometry, FSM states and the per-state output flags.
package carregador_instrucoes_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic byte_ready;
        logic imem_we;
        logic busy;
        logic done;
        logic cpu_rst_n;
    } flags_t;

    // Output flags that hold while the FSM sits in a given state
    function automatic flags_t state_flags(state_t s);
        flags_t f;
        f = '0;
        unique case (s)
            IDLE: f = '0;
            RECEIVE: begin
                f.byte_ready = 1'b1;
                f.busy       = 1'b1;
            end
            WRITE: begin
                f.imem_we = 1'b1;
                f.busy    = 1'b1;
            end
            DONE: begin
                f.done      = 1'b1;
                f.cpu_rst_n = 1'b1;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/carregador_instrucoes_if.sv
// Byte stream into the loader and word-write bus out to instruction memory.
// master drives the bytes; slave is the loader.
interface carregador_instrucoes_if
    import carregador_instrucoes_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/carregador_instrucoes_montador_palavra.sv
// Little-endian word assembler: drops each accepted byte into its lane
// and flags the transfer that completes a 32-bit word.
module montador_palavra (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic [31:0] palavra,
    output logic        word_ok
);

    logic [1:0] idx;

    assign word_ok = take && (idx == 2'd3);

    // Byte index counter and lane insert; clear drops any partial word
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            idx     <= 2'd0;
            palavra <= 32'd0;
        end else if (take) begin
            idx                       <= idx + 2'd1;
            palavra[{idx, 3'b000} +: 8] <= byte_in;
        end
    end

endmodule

// File: rtl/carregador_instrucoes.sv
// Program loader: streams bytes into instruction memory until a zero word,
// holding the datapath in reset until the load completes.
module carregador_instrucoes
    import carregador_instrucoes_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    carregador_instrucoes_if.slave  bus,
    output logic                    cpu_rst_n,
    output logic                    busy,
    output logic                    done,
    output logic                    erro,
    output logic [ADDR_W:0]         word_count
);

    state_t            state;
    flags_t            fl;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       palavra;
    logic              word_ok;
    logic              take;
    logic              load;

    assign take = bus.byte_valid && fl.byte_ready;
    assign load = start && ((state == IDLE) || (state == DONE));

    montador_palavra u_montador (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .take    (take),
        .byte_in (bus.byte_data),
        .palavra (palavra),
        .word_ok (word_ok)
    );

    assign bus.byte_ready = fl.byte_ready;
    assign bus.imem_we    = fl.imem_we;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = palavra;
    assign busy           = fl.busy;
    assign done           = fl.done;
    assign cpu_rst_n      = fl.cpu_rst_n;

    // Load sequencer with address counter, word count and overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            fl         <= state_flags(IDLE);
            addr       <= '0;
            word_count <= '0;
            erro       <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RECEIVE;
                        fl         <= state_flags(RECEIVE);
                        addr       <= '0;
                        word_count <= '0;
                        erro       <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (word_ok) begin
                        state <= WRITE;
                        fl    <= state_flags(WRITE);
                    end
                end
                WRITE: begin
                    word_count <= word_count + 1'b1;
                    if (palavra == 32'd0) begin
                        state <= DONE;
                        fl    <= state_flags(DONE);
                    end else if (addr == ADDR_W'(DEPTH - 1)) begin
                        state <= DONE;
                        fl    <= state_flags(DONE);
                        erro  <= 1'b1;
                    end else begin
                        state <= RECEIVE;
                        fl    <= state_flags(RECEIVE);
                        addr  <= addr + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Self-checking bench for carregador_instrucoes.
// Expected memory writes are queued when words are driven.
module tb_carregador_instrucoes;
    import carregador_instrucoes_pkg::*;

    localparam int AW  = IMEM_ADDR_W;
    localparam int DEP = IMEM_DEPTH;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          erro;
    logic [AW:0]   word_count;

    carregador_instrucoes_if #(.ADDR_W(AW)) bus ();

    carregador_instrucoes #(.DEPTH(DEP), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .erro       (erro),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [AW-1:0] qa[$];
    logic [31:0]   qd[$];
    int            wcyc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued word
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wcyc.push_back(cyc);
            chk("ready_in_write", 64'(bus.byte_ready), 0);
            if (qa.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                chk("we_addr", 64'(bus.imem_addr), 64'(qa.pop_front()));
                chk("we_data", 64'(bus.imem_wdata), 64'(qd.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w,
                             input int gapmax);
        logic [31:0] t;
        qa.push_back(a);
        qd.push_back(w);
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[7:0], gapmax > 0 ? int'($urandom_range(gapmax, 0)) : 0);
            t = t >> 8;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("done", 64'(done), 1);
        chk("sb_drained", 64'(qa.size()), 0);
    endtask

    initial begin
        logic [31:0] w;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_cpu_rst_n", 64'(cpu_rst_n), 0);
        chk("rst_erro", 64'(erro), 0);
        chk("rst_word_count", 64'(word_count), 0);
        chk("rst_byte_ready", 64'(bus.byte_ready), 0);
        chk("rst_imem_we", 64'(bus.imem_we), 0);
        chk("rst_imem_addr", 64'(bus.imem_addr), 0);
        chk("rst_imem_wdata", 64'(bus.imem_wdata), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cpu_rst_n", 64'(cpu_rst_n), 0);

        // Basic load with continuous bytes and write spacing
        wcyc.delete();
        pulse_start();
        chk("recv_busy", 64'(busy), 1);
        send_word(0, 32'h0050_0093, 0);
        send_word(1, 32'h0000_0000, 0);
        wait_done();
        chk("basic_wc", 64'(word_count), 2);
        chk("basic_erro", 64'(erro), 0);
        chk("basic_cpu_rst_n", 64'(cpu_rst_n), 1);
        chk("basic_busy", 64'(busy), 0);
        if (wcyc.size() == 2) chk("we_spacing", 64'(wcyc[1] - wcyc[0]), 5);
        else chk("we_count", 64'(wcyc.size()), 2);

        // Full memory with no terminator
        pulse_start();
        chk("start_in_done_cpu_rst_n", 64'(cpu_rst_n), 0);
        for (int i = 0; i < DEP; i++) begin
            w = 32'hA500_0000 | 32'(i + 1);
            send_word(AW'(i), w, 0);
        end
        wait_done();
        chk("full_erro", 64'(erro), 1);
        chk("full_wc", 64'(word_count), DEP);
        chk("full_addr_held", 64'(bus.imem_addr), DEP - 1);

        // Reset in the middle of the third word
        pulse_start();
        send_word(0, 32'h1111_2222, 0);
        send_word(1, 32'h3333_4444, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_outs", 64'({busy, done, cpu_rst_n, erro,
                                bus.byte_ready, bus.imem_we}), 0);
        chk("midrst_wc", 64'(word_count), 0);
        chk("midrst_addr", 64'(bus.imem_addr), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_we", 64'(bus.imem_we), 0);
        pulse_start();
        send_word(0, 32'h0000_0000, 0);
        wait_done();
        chk("postrst_wc", 64'(word_count), 1);

        // Start ignored mid-load, honoured in DONE
        pulse_start();
        send_word(0, 32'hCAFE_F00D, 0);
        pulse_start();
        pulse_start();
        chk("ign_start_wc", 64'(word_count), 1);
        chk("ign_start_addr", 64'(bus.imem_addr), 1);
        chk("ign_start_busy", 64'(busy), 1);
        send_word(1, 32'h0000_0000, 0);
        wait_done();
        chk("ign_start_total", 64'(word_count), 2);
        pulse_start();
        chk("reload_cpu_rst_n", 64'(cpu_rst_n), 0);
        chk("reload_wc", 64'(word_count), 0);
        send_word(0, 32'hDEAD_BEEF, 0);
        send_word(1, 32'h0000_0000, 0);
        wait_done();

        // Random gaps between bytes
        pulse_start();
        send_word(0, 32'h0050_0093, 4);
        for (int i = 1; i < 4; i++) begin
            w = $urandom | 32'h0000_0100;
            send_word(AW'(i), w, 5);
        end
        send_word(4, 32'h0000_0000, 3);
        wait_done();
        chk("gaps_wc", 64'(word_count), 5);
        chk("gaps_erro", 64'(erro), 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/carregador_instrucoes.md
CARREGADOR_INSTRUCOES -- requirements
Module: carregador_instrucoes

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in instruction memory.
REQ-002 Parameter ADDR_W, default 6, instruction memory address width, equal to log2(DEPTH).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset: synchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 byte_valid  input  1  source presents a program byte.
REQ-007 byte_data  input  8  program byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  32  instruction word to write.
REQ-012 cpu_rst_n  output  1  active-low hold for the datapath; the datapath runs only when this is 1.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load complete.
REQ-015 erro  output  1  DEPTH words written with no zero terminator.
REQ-016 word_count  output  ADDR_W+1  words written in the current load, 0..DEPTH.

Function
REQ-017 The FSM SHALL use four states: IDLE, RECEIVE, WRITE, DONE.
REQ-018 In IDLE, start=1 SHALL move the FSM to RECEIVE and clear the byte index, address, word_count and erro.
REQ-019 In RECEIVE, byte_ready SHALL be 1; it SHALL be 0 in all other states.
REQ-020 A byte transfers only on a cycle with byte_valid=1 and byte_ready=1; byte_valid without byte_ready is ignored and not buffered.
REQ-021 Bytes SHALL assemble little-endian: byte 0 -> bits 7:0, byte 1 -> 15:8, byte 2 -> 23:16, byte 3 -> 31:24.
REQ-022 The cycle after the 4th byte transfers, the FSM SHALL be in WRITE for exactly one cycle.
REQ-023 During WRITE, imem_we SHALL be 1 with the assembled word on imem_wdata and the current address on imem_addr; imem_we SHALL be 0 in every other cycle.
REQ-024 On leaving WRITE, word_count SHALL increment by 1.
REQ-025 On leaving WRITE with a written word of 0 (halt terminator), the FSM SHALL go to DONE; the terminator is written to memory.
REQ-026 On leaving WRITE with a non-zero word at address DEPTH-1, the FSM SHALL go to DONE, set erro=1, and hold the address at DEPTH-1 (no wrap).
REQ-027 Otherwise, on leaving WRITE the address SHALL increment and the FSM SHALL return to RECEIVE.
REQ-028 Latency from the 4th accepted byte to imem_we SHALL be 1 cycle; maximum throughput SHALL be 4 bytes per 5 cycles.
REQ-029 cpu_rst_n SHALL be 1 only in DONE and 0 in IDLE, RECEIVE and WRITE.
REQ-030 busy SHALL be 1 in RECEIVE and WRITE; done SHALL be 1 in DONE only.
REQ-031 start in RECEIVE or WRITE SHALL be ignored.
REQ-032 start in DONE SHALL begin a new load exactly as from IDLE, and drive cpu_rst_n to 0 on the next cycle.
REQ-033 A partial word (1-3 bytes received) SHALL never be written.

Reset
REQ-034 rst=0 at a clock edge SHALL force IDLE and clear the byte index, address, assembly register and word_count, regardless of state.
REQ-035 The reset value of every output SHALL be 0, including cpu_rst_n.
REQ-036 Reset mid-load SHALL discard the partial word, and no imem_we SHALL occur in the cycle after reset.

Structure
REQ-037 State encodings, DEPTH and ADDR_W SHALL reside in a shared package, also used by the instruction-memory reader.
REQ-038 Byte assembly SHALL be a sub-module montador_palavra (byte index counter, 32-bit shift/insert register, word_ok pulse); the FSM, address counter and flags remain in the top module.

Verification
REQ-039 Load 0x00500093 (bytes 93 00 50 00) then 00 00 00 00 -> imem_we at addr 0 with 0x00500093 and at addr 1 with 0x00000000; done=1, word_count=2, erro=0, cpu_rst_n=1.
REQ-040 byte_valid held continuously for 8 bytes -> imem_we pulses exactly 5 cycles apart, and byte_ready is 0 during each WRITE cycle.
REQ-041 Send 64 non-zero words with no terminator -> last write at addr 63, done=1, erro=1, word_count=64, no write to addr 0 after the first word.
REQ-042 Pulse rst=0 after 2 bytes of the 3rd word -> IDLE, all outputs 0; then start with 1 word 0 -> write at addr 0, word_count=1.
REQ-043 start pulsed during RECEIVE -> address and word_count unchanged; start in DONE -> cpu_rst_n=0 next cycle and the next write goes to addr 0.
REQ-044 Gaps of random length between bytes -> assembled words are identical to the gap-free case.
